inst_mem_loader: RTL
====================

Name: inst_mem_loader

Overview:
- Hardware program loader for the CPU's instruction memory, replacing simulation-only backdoor loading of the program image.
- Accepts the program as a byte stream over a valid/ready handshake and assembles 32-bit instruction words, MSB byte first.
- Writes each word into consecutive instruction-memory locations and holds the CPU in reset until the image is complete.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load, sampled only in IDLE or DONE.
- load_len  input  ADDR_W+1  number of 32-bit words to load; sampled on accepted start.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  instruction-memory word address.
- mem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  active-high; the integration inverts it onto the CPU's rst_n.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- err  output  1  length error, sticky until the next accepted start.

Behaviour:
- Reset (asynchronous), all outputs:
  - state = IDLE, cpu_hold = 1, byte_ready = 0, mem_we = 0.
  - mem_addr = BASE_ADDR, mem_wdata = 0, busy = 0, done = 0, err = 0.
  - Byte counter = 0, word counter = 0.
- States:
  - IDLE: cpu_hold = 1. On start, go to LOAD.
  - LOAD: busy = 1, byte_ready = 1, cpu_hold = 1.
  - DONE: done = 1, cpu_hold = 0, byte_ready = 0.
- Start handling:
  - IDLE/DONE with start = 1: latch load_len, clear err, byte counter = 0, word counter = 0, mem_addr = BASE_ADDR.
  - load_len == 0: go directly to DONE next cycle; no writes.
  - load_len > 2^ADDR_W - BASE_ADDR: err = 1, go to DONE next cycle, no writes, cpu_hold = 0.
  - Otherwise go to LOAD.
  - start in LOAD is ignored.
- Byte transfer:
  - A byte is accepted on the edge where byte_valid & byte_ready.
  - Bytes shift into a 32-bit assembly register: word = {b0, b1, b2, b3}.
  - Byte counter is 2 bits and wraps 3 -> 0.
- Word write:
  - Accepting the 4th byte of a word registers mem_wdata and asserts mem_we on the following cycle, for exactly one cycle.
  - mem_addr holds the word's address during that cycle; it increments by 1 on the cycle after mem_we.
  - byte_ready stays high during mem_we, so back-to-back streaming sustains 1 byte/cycle with no bubbles.
  - mem_addr never wraps, because oversize lengths are rejected at start.
- Completion:
  - The cycle after the final mem_we, state = DONE; done and cpu_hold update on that same edge.
  - byte_ready drops on the edge that accepts the final byte; no extra byte is accepted.
- byte_valid low stalls assembly indefinitely; the state is held.
- DONE is terminal until the next start.
  - A start in DONE re-asserts cpu_hold on the next edge, reloading the image.
- Reset mid-load: immediate return to IDLE values.
  - Partial words are discarded; mem_we deasserts asynchronously.
  - Memory already written is not restored.
- Single start-acceptance arbitration: no simultaneous-event conflicts beyond the rules above.

Test Plan:
- Reset then idle: hold rst = 1 for 2 cycles, release -> cpu_hold = 1, done = 0, byte_ready = 0, mem_we never asserts.
- Basic load: start with load_len = 2, bytes 8C,01,00,04,AC,02,00,08 on consecutive cycles ->
  - mem_we at addr 0 with 8C010004.
  - mem_we at addr 1 with AC020008.
  - done = 1 and cpu_hold = 0 one cycle after the second write.
- Stalls: same stream with byte_valid dropped for 3 cycles between bytes 2 and 3 -> identical writes and data; no write issued before byte 4.
- Edge lengths:
  - load_len = 0 -> DONE after 1 cycle, no mem_we, err = 0.
  - load_len = 257 with ADDR_W = 8 -> err = 1, DONE, no mem_we.
  - load_len = 256 -> 256 writes, last at addr FF.
- Reset mid-word: assert rst after 2 bytes of word 0 -> outputs return to reset values immediately; a new load of 1 word writes addr 0 with only the new bytes.
- Reload: after a completed load, start with load_len = 1 -> cpu_hold returns to 1 on the next edge, one write at addr 0, then DONE.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Program loader for the CPU instruction memory: assembles a byte stream
// (MSB byte first) into 32-bit words, writes them to consecutive word
// addresses starting at BASE_ADDR, and holds the CPU in reset until done.
module inst_mem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [ADDR_W:0]   MAX_LEN   = LEN_W'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic                accept;

    // Bytes are accepted in LOAD until every word of the image has been
    // assembled; ready therefore drops on the edge taking the final byte.
    assign byte_ready = (state_q == LOAD) && (word_cnt_q != len_q);
    assign accept     = byte_valid && byte_ready;

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign cpu_hold   = (state_q != DONE);
    assign err        = err_q;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= BASE_WORD;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: start arbitration, byte assembly and word write.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        err_d      = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d      = load_len;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    addr_d     = BASE_WORD;
                    if (load_len == '0) begin
                        state_d = DONE;
                    end else if (load_len > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wdata_d    = {asm_q, byte_data};
                        we_d       = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end else begin
                        asm_d = {asm_q[15:0], byte_data};
                    end
                end
                // The address advances after each write except the last, so it
                // never leaves the legal range even for a full-depth image.
                if (we_q) begin
                    if (word_cnt_q == len_q) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
